// File: rtl/adat_frame_decoder.sv
// adat_frame_decoder
//   Decodes ADAT frames from the subframe words produced by the upstream frame
//   detector. It checks the nibble-sync bits, assembles the eight 24-bit
//   channel samples and the four user bits, and tracks frame-lock status.
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous, active-high reset
//   subframe_data in   10-bit word {1,nibA[3:0],1,nibB[3:0]}, [9] oldest bit
//   subframe_rdy  in   one-cycle strobe, subframe_data valid
//   frame_rdy     in   one-cycle strobe, sync seen, new frame starts
//   det_error     in   detector run-length error flag
//   sample_data   out  assembled 24-bit sample, MSB nibble first
//   sample_chan   out  channel index 0..7 of sample_data
//   sample_valid  out  one-cycle strobe, sample_data/sample_chan valid
//   user_bits     out  user bits of the last good user word
//   frame_done    out  one-cycle strobe, all 8 channels of a frame delivered
//   fmt_err       out  one-cycle strobe, framing/format error detected
//   locked        out  LOCK_FRAMES consecutive clean frames, no error since
module adat_frame_decoder #(
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  subframe_data,
    input  logic        subframe_rdy,
    input  logic        frame_rdy,
    input  logic        det_error,
    output logic [23:0] sample_data,
    output logic [2:0]  sample_chan,
    output logic        sample_valid,
    output logic [3:0]  user_bits,
    output logic        frame_done,
    output logic        fmt_err,
    output logic        locked
);

    typedef enum logic [1:0] {
        IDLE,
        USER,
        DATA,
        WAIT_SYNC
    } state_t;

    localparam logic [3:0] LOCK_TH = 4'(LOCK_FRAMES);

    state_t      state;
    logic [4:0]  word_cnt;
    logic [1:0]  phase;      // position of the word within its channel (0..2)
    logic [2:0]  chan_cnt;
    logic [23:0] asm_reg;
    logic [3:0]  lock_cnt;

    logic        accept;
    logic        short_err;
    logic        det_err;
    logic        sync_err;
    logic        any_err;
    logic [23:0] asm_next;

    // frame_rdy takes precedence: a word arriving with it is dropped.
    always_comb begin
        accept    = subframe_rdy && !frame_rdy;
        short_err = frame_rdy && (state == USER || state == DATA);
        det_err   = det_error && (state != IDLE);
        sync_err  = 1'b0;
        if (accept && state == USER && !subframe_data[4])
            sync_err = 1'b1;
        if (accept && state == DATA && (!subframe_data[9] || !subframe_data[4]))
            sync_err = 1'b1;
        any_err   = short_err || det_err || sync_err;
        asm_next  = {asm_reg[15:0], subframe_data[8:5], subframe_data[3:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            word_cnt     <= '0;
            phase        <= '0;
            chan_cnt     <= '0;
            asm_reg      <= '0;
            lock_cnt     <= '0;
            sample_data  <= '0;
            sample_chan  <= '0;
            sample_valid <= 1'b0;
            user_bits    <= '0;
            frame_done   <= 1'b0;
            fmt_err      <= 1'b0;
            locked       <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            frame_done   <= 1'b0;
            fmt_err      <= 1'b0;

            if (any_err) begin
                // A detector error means the bit stream itself is suspect, so
                // it overrides a coincident short-frame restart.
                fmt_err <= 1'b1;
                state   <= (short_err && !det_err) ? USER : IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (frame_rdy)
                            state <= USER;
                    end
                    USER: begin
                        if (accept) begin
                            user_bits <= subframe_data[3:0];
                            word_cnt  <= '0;
                            phase     <= '0;
                            chan_cnt  <= '0;
                            state     <= DATA;
                        end
                    end
                    DATA: begin
                        if (accept) begin
                            asm_reg  <= asm_next;
                            word_cnt <= word_cnt + 5'd1;
                            if (phase == 2'd2) begin
                                phase        <= '0;
                                chan_cnt     <= chan_cnt + 3'd1;
                                sample_valid <= 1'b1;
                                sample_data  <= asm_next;
                                sample_chan  <= chan_cnt;
                            end else begin
                                phase <= phase + 2'd1;
                            end
                            if (word_cnt == 5'd23) begin
                                frame_done <= 1'b1;
                                state      <= WAIT_SYNC;
                                if (lock_cnt != 4'hF)
                                    lock_cnt <= lock_cnt + 4'd1;
                            end
                        end
                    end
                    WAIT_SYNC: begin
                        if (frame_rdy)
                            state <= USER;
                    end
                    default: state <= IDLE;
                endcase
            end

            // Any error, including det_error while idle, restarts lock counting
            // and drops locked together with the fmt_err pulse.
            if (any_err || det_error) begin
                lock_cnt <= '0;
                locked   <= 1'b0;
            end else begin
                locked <= (lock_cnt >= LOCK_TH);
            end
        end
    end

endmodule

// File: tb/tb_adat_frame_decoder.sv
// tb_adat_frame_decoder
//   Directed self-checking bench for adat_frame_decoder with LOCK_FRAMES = 2.
module tb_adat_frame_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  subframe_data;
    logic        subframe_rdy;
    logic        frame_rdy;
    logic        det_error;
    logic [23:0] sample_data;
    logic [2:0]  sample_chan;
    logic        sample_valid;
    logic [3:0]  user_bits;
    logic        frame_done;
    logic        fmt_err;
    logic        locked;

    always #5 clk = ~clk;

    adat_frame_decoder #(.LOCK_FRAMES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .subframe_data(subframe_data),
        .subframe_rdy (subframe_rdy),
        .frame_rdy    (frame_rdy),
        .det_error    (det_error),
        .sample_data  (sample_data),
        .sample_chan  (sample_chan),
        .sample_valid (sample_valid),
        .user_bits    (user_bits),
        .frame_done   (frame_done),
        .fmt_err      (fmt_err),
        .locked       (locked)
    );

    localparam logic [9:0]  W_USER_A = 10'b0000011010;  // user bits 0xA
    localparam logic [9:0]  W_USER_5 = 10'b0000010101;  // user bits 0x5
    localparam logic [9:0]  W_USER_3 = 10'b0000010011;  // user bits 0x3
    localparam logic [9:0]  W_USER_C = 10'b0000011100;  // user bits 0xC
    localparam logic [9:0]  W_DATA   = 10'b1101010110;  // A=0xA, B=0x6
    localparam logic [9:0]  W_BAD9   = 10'b0101010110;  // [9] = 0
    localparam logic [23:0] SAMPLE   = 24'hA6A6A6;

    int checks = 0;
    int errors = 0;

    // Pulse log written only by this monitor; tasks compare against deltas.
    int          fe_total = 0;
    int          fd_total = 0;
    int          fd_ok_total = 0;
    logic [2:0]  chan_q[$];
    logic [23:0] data_q[$];

    always @(negedge clk) begin
        if (sample_valid) begin
            chan_q.push_back(sample_chan);
            data_q.push_back(sample_data);
        end
        if (fmt_err)
            fe_total++;
        if (frame_done) begin
            fd_total++;
            if (sample_valid && sample_chan == 3'd7)
                fd_ok_total++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        step();
        step();
    endtask

    task automatic send_word(input logic [9:0] w);
        subframe_data = w;
        subframe_rdy  = 1'b1;
        step();
        subframe_rdy  = 1'b0;
    endtask

    task automatic send_data(input int n);
        for (int i = 0; i < n; i++)
            send_word(W_DATA);
    endtask

    task automatic pulse_frame();
        frame_rdy = 1'b1;
        step();
        frame_rdy = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        subframe_data = '0;
        subframe_rdy  = 1'b0;
        frame_rdy     = 1'b0;
        det_error     = 1'b0;
        do_reset();
        checks++;
        if ({sample_data, sample_chan, sample_valid, user_bits, frame_done, fmt_err, locked} !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs: data=%h chan=%0d sv=%b ub=%h fd=%b fe=%b lk=%b, required all 0",
                     sample_data, sample_chan, sample_valid, user_bits, frame_done, fmt_err, locked);
        end
    endtask

    task automatic test_clean_frame();
        int base, fe0, fd0, fo0;
        base = chan_q.size(); fe0 = fe_total; fd0 = fd_total; fo0 = fd_ok_total;
        pulse_frame();
        send_word(W_USER_A);
        checks++;
        if (user_bits !== 4'hA) begin
            errors++; $display("FAIL clean_user_bits: got %h, required a", user_bits);
        end
        send_data(24);
        settle();
        checks++;
        if (chan_q.size() - base !== 8) begin
            errors++; $display("FAIL clean_sample_count: got %0d, required 8", chan_q.size() - base);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (chan_q[base+i] !== 3'(i) || data_q[base+i] !== SAMPLE) begin
                    errors++;
                    $display("FAIL clean_sample_%0d: chan=%0d data=%h, required chan=%0d data=%h",
                             i, chan_q[base+i], data_q[base+i], i, SAMPLE);
                end
            end
        end
        checks++;
        if (fd_total - fd0 !== 1 || fd_ok_total - fo0 !== 1) begin
            errors++; $display("FAIL clean_frame_done: pulses=%0d with_chan7=%0d, required 1 and 1",
                               fd_total - fd0, fd_ok_total - fo0);
        end
        checks++;
        if (fe_total - fe0 !== 0) begin
            errors++; $display("FAIL clean_fmt_err: pulses=%0d, required 0", fe_total - fe0);
        end
    endtask

    task automatic test_lock();
        int base, fe0;
        do_reset();
        pulse_frame(); send_word(W_USER_A); send_data(24);
        pulse_frame(); send_word(W_USER_A); send_data(23);
        send_word(W_DATA);
        checks++;
        if (frame_done !== 1'b1 || locked !== 1'b0) begin
            errors++; $display("FAIL lock_second_done: frame_done=%b locked=%b, required 1 and 0", frame_done, locked);
        end
        step();
        checks++;
        if (locked !== 1'b1) begin
            errors++; $display("FAIL lock_rise: locked=%b, required 1", locked);
        end
        pulse_frame(); send_word(W_USER_A); send_data(24);
        pulse_frame(); send_word(W_USER_A);
        base = chan_q.size();
        send_data(4);
        checks++;
        if (locked !== 1'b1) begin
            errors++; $display("FAIL lock_held: locked=%b, required 1", locked);
        end
        send_word(W_BAD9);
        checks++;
        if (fmt_err !== 1'b1 || locked !== 1'b0) begin
            errors++; $display("FAIL lock_sync_err: fmt_err=%b locked=%b, required 1 and 0", fmt_err, locked);
        end
        send_data(3);
        settle();
        checks++;
        if (chan_q.size() - base !== 1 || chan_q[base] !== 3'd0) begin
            errors++; $display("FAIL lock_partial_samples: count=%0d first_chan=%0d, required 1 and 0",
                               chan_q.size() - base, chan_q[base]);
        end
        // det_error only raises fmt_err outside IDLE, so silence here means IDLE.
        fe0 = fe_total;
        det_error = 1'b1; step(); det_error = 1'b0;
        settle();
        checks++;
        if (fe_total - fe0 !== 0) begin
            errors++; $display("FAIL lock_idle_after_err: fmt_err pulses=%0d, required 0", fe_total - fe0);
        end
    endtask

    task automatic test_short_frame();
        int base, fe0, fd0;
        base = chan_q.size(); fe0 = fe_total; fd0 = fd_total;
        pulse_frame(); send_word(W_USER_A); send_data(10);
        pulse_frame();
        checks++;
        if (fmt_err !== 1'b1) begin
            errors++; $display("FAIL short_fmt_err: got %b, required 1", fmt_err);
        end
        send_word(W_USER_5);
        checks++;
        if (user_bits !== 4'h5) begin
            errors++; $display("FAIL short_user_bits: got %h, required 5", user_bits);
        end
        send_data(24);
        settle();
        checks++;
        if (chan_q.size() - base !== 11) begin
            errors++; $display("FAIL short_sample_count: got %0d, required 11", chan_q.size() - base);
        end else begin
            for (int i = 0; i < 11; i++) begin
                checks++;
                if (chan_q[base+i] !== 3'(i < 3 ? i : i - 3)) begin
                    errors++; $display("FAIL short_chan_%0d: got %0d, required %0d",
                                       i, chan_q[base+i], (i < 3 ? i : i - 3));
                end
            end
        end
        checks++;
        if (fe_total - fe0 !== 1 || fd_total - fd0 !== 1) begin
            errors++; $display("FAIL short_pulses: fmt_err=%0d frame_done=%0d, required 1 and 1",
                               fe_total - fe0, fd_total - fd0);
        end
    endtask

    task automatic test_collision();
        int base, fe0, fd0;
        base = chan_q.size(); fe0 = fe_total; fd0 = fd_total;
        subframe_data = W_DATA;
        subframe_rdy  = 1'b1;
        frame_rdy     = 1'b1;
        step();
        subframe_rdy  = 1'b0;
        frame_rdy     = 1'b0;
        send_word(W_USER_3);
        checks++;
        if (user_bits !== 4'h3) begin
            errors++; $display("FAIL collision_user_bits: got %h, required 3", user_bits);
        end
        send_data(24);
        for (int i = 0; i < 3; i++)
            send_word(10'b0000000000);
        settle();
        checks++;
        if (chan_q.size() - base !== 8 || fd_total - fd0 !== 1 || fe_total - fe0 !== 0) begin
            errors++; $display("FAIL collision_frame: samples=%0d frame_done=%0d fmt_err=%0d, required 8, 1, 0",
                               chan_q.size() - base, fd_total - fd0, fe_total - fe0);
        end
    endtask

    task automatic test_reset_mid();
        int base, fe0, fd0;
        base = chan_q.size(); fe0 = fe_total; fd0 = fd_total;
        pulse_frame(); send_word(W_USER_A); send_data(7);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({sample_data, sample_chan, sample_valid, user_bits, frame_done, fmt_err, locked} !== 36'd0) begin
            errors++;
            $display("FAIL midreset_outputs: data=%h chan=%0d sv=%b ub=%h fd=%b fe=%b lk=%b, required all 0",
                     sample_data, sample_chan, sample_valid, user_bits, frame_done, fmt_err, locked);
        end
        send_data(5);
        settle();
        checks++;
        if (chan_q.size() - base !== 2 || fd_total - fd0 !== 0 || fe_total - fe0 !== 0) begin
            errors++; $display("FAIL midreset_quiet: samples=%0d frame_done=%0d fmt_err=%0d, required 2, 0, 0",
                               chan_q.size() - base, fd_total - fd0, fe_total - fe0);
        end
        pulse_frame();
        send_word(W_USER_C);
        send_data(24);
        settle();
        checks++;
        if (user_bits !== 4'hC || chan_q.size() - base !== 10 || fd_total - fd0 !== 1) begin
            errors++; $display("FAIL midreset_recover: ub=%h samples=%0d frame_done=%0d, required c, 10, 1",
                               user_bits, chan_q.size() - base, fd_total - fd0);
        end
    endtask

    task automatic test_det_error();
        int base;
        do_reset();
        pulse_frame(); send_word(W_USER_A); send_data(24);
        pulse_frame(); send_word(W_USER_A); send_data(24);
        settle();
        checks++;
        if (locked !== 1'b1) begin
            errors++; $display("FAIL deterr_pre_lock: locked=%b, required 1", locked);
        end
        pulse_frame(); send_word(W_USER_A);
        base = chan_q.size();
        send_data(5);
        det_error = 1'b1; step(); det_error = 1'b0;
        checks++;
        if (fmt_err !== 1'b1 || locked !== 1'b0) begin
            errors++; $display("FAIL deterr_data: fmt_err=%b locked=%b, required 1 and 0", fmt_err, locked);
        end
        settle();
        checks++;
        if (chan_q.size() - base !== 1) begin
            errors++; $display("FAIL deterr_samples: got %0d, required 1", chan_q.size() - base);
        end
        det_error = 1'b1; step(); det_error = 1'b0;
        checks++;
        if (fmt_err !== 1'b0) begin
            errors++; $display("FAIL deterr_idle: fmt_err=%b, required 0", fmt_err);
        end
        pulse_frame(); send_word(W_USER_A); send_data(24);
        settle();
        checks++;
        if (locked !== 1'b0) begin
            errors++; $display("FAIL deterr_relock_one: locked=%b, required 0", locked);
        end
        pulse_frame(); send_word(W_USER_A); send_data(24);
        settle();
        checks++;
        if (locked !== 1'b1) begin
            errors++; $display("FAIL deterr_relock_two: locked=%b, required 1", locked);
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_clean_frame();
        test_lock();
        test_short_frame();
        test_collision();
        test_reset_mid();
        test_det_error();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adat_frame_decoder.md
Name: adat_frame_decoder

Overview:
- Sits directly downstream of the ADAT frame detector in the ADAT receive path.
- Consumes its 10-bit subframe words, frame-start strobe and error flag, and checks the nibble-sync bits.
- Assembles 8 channels of 24-bit samples and the 4 user bits.
- Tracks frame-lock status for the channel demux / FIFO stage that follows.

Parameters:
- LOCK_FRAMES, 2, consecutive clean frames required before locked asserts (1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- subframe_data  in  10  word from detector; [9] oldest bit; layout {1,nibA[3:0],1,nibB[3:0]}
- subframe_rdy  in  1  one-cycle strobe: subframe_data valid
- frame_rdy  in  1  one-cycle strobe: sync pattern seen, new frame starts
- det_error  in  1  detector run-length error flag
- sample_data  out  24  assembled sample, MSB nibble first
- sample_chan  out  3  channel index 0..7 of sample_data
- sample_valid  out  1  one-cycle strobe: sample_data/sample_chan valid
- user_bits  out  4  user bits of last good user word
- frame_done  out  1  one-cycle strobe: all 8 channels of a frame delivered
- fmt_err  out  1  one-cycle strobe: framing/format error detected
- locked  out  1  LOCK_FRAMES consecutive clean frames seen, no error since

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; lock count 0. Reset mid-frame discards the partial frame without raising fmt_err.
- Each frame is 1 user word followed by 24 data words. Each data word carries 2 nibbles: nibA = [8:5], nibB = [3:0]. 3 data words make 1 channel; channels arrive 0..7.
- FSM states:
  - IDLE: wait for frame_rdy, then go to USER. subframe_rdy is ignored.
  - USER: the next subframe_rdy is the user word. Bit [4] must be 1, else error. If good, user_bits <= [3:0] (registered, visible the next cycle, held until the next good user word). Then go to DATA with word_cnt = 0.
  - DATA: on each subframe_rdy, check [9]==1 and [4]==1, else error. Shift {nibA,nibB} into the 24-bit assembly register; word_cnt increments 0..23.
    - On words 2, 5, ..., 23 (third word of a channel): the next cycle, sample_valid=1, sample_chan=word_cnt/3, sample_data=assembled value.
    - On word 23: frame_done=1 in the same cycle as channel 7's sample_valid. Go to WAIT_SYNC.
  - WAIT_SYNC: subframe_rdy is ignored, since the detector emits junk words during sync zeros. frame_rdy goes to USER.
- Latency: 1 clock from the accepting subframe_rdy to sample_valid / frame_done / fmt_err.
- Precedence: frame_rdy and subframe_rdy in the same cycle means frame_rdy wins and the subframe word is dropped.
- Error events, each raising fmt_err for 1 cycle the next clock:
  - a sync-bit violation;
  - frame_rdy while in USER or DATA (short frame);
  - det_error=1 while in USER, DATA or WAIT_SYNC.
- Error handling:
  - A short frame restarts in USER. Any other error goes to IDLE.
  - No further sample_valid for that frame; samples already emitted stand.
  - Lock count clears and locked drops the next cycle.
  - Simultaneous errors give one fmt_err pulse.
- Lock counting:
  - A clean frame is one reaching frame_done with no error since its frame_rdy; it increments the 4-bit lock count, saturating at 15.
  - locked = (count >= LOCK_FRAMES), registered.
- sample_data holds its value between strobes; sample_chan likewise.
- det_error in IDLE is ignored: no pulse, but the lock count is still cleared.

Test Plan:
- Clean frame: frame_rdy; user word 10'b0000011010; 24 words all 10'b1101010110 (A=0xA, B=0x6) -> user_bits=4'hA; 8 sample_valid pulses with chan 0..7, each sample_data=24'hA6A6A6; frame_done with chan 7; fmt_err never.
- Lock: 3 clean frames with LOCK_FRAMES=2 -> locked rises 1 cycle after the 2nd frame_done. Then corrupt word 4 ([9]=0) in frame 4 -> fmt_err 1 cycle later, locked=0, only channel 0 emitted, FSM IDLE.
- Short frame: frame_rdy after 10 data words -> fmt_err; 3 samples emitted (chan 0..2). The next 25 words decode as a full frame with correct user_bits.
- Collision and sync junk: frame_rdy and subframe_rdy in the same cycle -> word dropped, next word treated as user word. 3 subframe_rdy in WAIT_SYNC -> ignored, no fmt_err.
- Reset mid-DATA (word 7): no sample_valid/frame_done/fmt_err afterwards; all outputs 0; the next frame decodes normally.
- det_error pulse in DATA -> fmt_err next cycle, locked cleared; det_error in IDLE -> no fmt_err.
